uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module  : uart_pkg
//  Brief   : Shared UART constants and receiver state encoding.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module  : uart_baud_tick
//  Brief   : Oversample tick generator; period is clk_div+1 clk cycles.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             restart,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;

   // clk_div is only picked up at reload, so a mid-period change never truncates a tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (restart || (r_cnt == '0)) begin
         r_cnt <= clk_div;
      end else begin
         r_cnt <= r_cnt - DIV_W'(1);
      end
   end

   assign tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module  : uart_rx
//  Brief   : 8N1 UART receiver, 16x oversampled, single-entry holding register.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DIV_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [DIV_W-1:0]          clk_div,
   input  logic                      rx,
   output logic                      rx_valid,
   output logic [UART_DATA_BITS-1:0] rx_data,
   input  logic                      rx_ready,
   output logic                      framing_err,
   output logic                      overrun
);

   localparam int                c_OS_W     = $clog2(OVERSAMPLE);
   localparam int                c_BIT_W    = $clog2(UART_DATA_BITS);
   localparam logic [c_OS_W-1:0]  c_OS_HALF  = c_OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(UART_DATA_BITS - 1);

   logic [1:0]                r_sync;
   logic                      w_sync_rx;
   uart_state_e               r_state;
   uart_state_e               w_state_next;
   logic [c_OS_W-1:0]         r_os_cnt;
   logic [c_BIT_W-1:0]        r_bit_idx;
   logic [UART_DATA_BITS-1:0] r_shift;

   logic w_tick;
   logic w_restart;
   logic w_os_clr;
   logic w_bit_clr;
   logic w_shift_en;
   logic w_deliver;
   logic w_ferr;

   assign w_sync_rx = r_sync[1];

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_div (clk_div),
      .restart (w_restart),
      .tick    (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_restart    = 1'b0;
      w_os_clr     = 1'b0;
      w_bit_clr    = 1'b0;
      w_shift_en   = 1'b0;
      w_deliver    = 1'b0;
      w_ferr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Reloading the tick counter on the edge anchors every sample point to it
            if (!w_sync_rx) begin
               w_state_next = ST_START;
               w_restart    = 1'b1;
               w_os_clr     = 1'b1;
            end
         end
         ST_START: begin
            if (w_tick && (r_os_cnt == c_OS_HALF)) begin
               w_os_clr     = 1'b1;
               w_bit_clr    = 1'b1;
               w_state_next = w_sync_rx ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_tick && (r_os_cnt == c_OS_LAST)) begin
               w_os_clr   = 1'b1;
               w_shift_en = 1'b1;
               if (r_bit_idx == c_BIT_LAST) begin
                  w_state_next = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (w_tick && (r_os_cnt == c_OS_LAST)) begin
               w_os_clr = 1'b1;
               if (w_sync_rx) begin
                  w_deliver    = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_ferr       = 1'b1;
                  w_state_next = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (w_sync_rx) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync      <= 2'b11;
         r_os_cnt    <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], rx};
         framing_err <= w_ferr;
         overrun     <= 1'b0;

         if (w_os_clr) begin
            r_os_cnt <= '0;
         end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + c_OS_W'(1);
         end

         if (w_bit_clr) begin
            r_bit_idx <= '0;
         end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + c_BIT_W'(1);
         end

         if (w_shift_en) begin
            r_shift <= {w_sync_rx, r_shift[UART_DATA_BITS-1:1]};
         end

         // A read in the delivery cycle frees the slot, so the new byte replaces the old
         if (w_deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= r_shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module  : tb_uart_rx
//  Brief   : Scoreboard bench for uart_rx, clk_div=3, 64 clk cycles per bit.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
   import uart_pkg::*;

   localparam int c_BIT_CYC = 64;

   logic        clk;
   logic        reset_n;
   logic [15:0] clk_div;
   logic        rx;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        framing_err;
   logic        overrun;

   int          n_cmp;
   int          n_err;
   int          cyc;
   int          t_fall;
   int          t_rise;
   int          n_loads;
   int          n_ferr;
   int          n_ovr;
   logic        prev_valid;
   logic [7:0]  exp_q[$];

   uart_rx #(
      .OVERSAMPLE (16),
      .DIV_W      (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clk_div     (clk_div),
      .rx          (rx),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .framing_err (framing_err),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed byte is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_valid && !prev_valid) begin
            n_loads++;
            t_rise = cyc;
         end
         if (framing_err) n_ferr++;
         if (overrun) n_ovr++;
         if (rx_valid && rx_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
            end else begin
               automatic logic [7:0] e = exp_q.pop_front();
               if (rx_data !== e) begin
                  n_err++;
                  $display("FAIL rx_data: got 0x%0h expected 0x%0h", rx_data, e);
               end
            end
         end
      end
      prev_valid = rx_valid;
   end

   task automatic drive_frame(input logic [9:0] frame, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         rx = frame[i / c_BIT_CYC];
         if (i == 0) t_fall = cyc;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      drive_frame({1'b1, b, 1'b0}, 10 * c_BIT_CYC);
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int loads0;
      n_cmp = 0; n_err = 0; cyc = 0; t_fall = 0; t_rise = 0;
      n_loads = 0; n_ferr = 0; n_ovr = 0; prev_valid = 1'b0;
      reset_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; clk_div = 16'd3;

      repeat (3) @(negedge clk);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_framing_err", {31'd0, framing_err}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      idle_cycles(20);

      // Single byte, held until read
      loads0 = n_loads;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5);
      idle_cycles(10);
      check("single_loads", n_loads - loads0, 32'd1);
      check("single_latency_ok", {31'd0, ((t_rise - t_fall) >= 610) && ((t_rise - t_fall) <= 614)}, 32'd1);
      check("single_valid_held", {31'd0, rx_valid}, 32'd1);
      check("single_data", {24'd0, rx_data}, 32'hA5);
      check("single_flags", n_ferr + n_ovr, 32'd0);
      pulse_ready();
      @(negedge clk);
      check("single_valid_cleared", {31'd0, rx_valid}, 32'd0);
      check("single_queue_empty", exp_q.size(), 32'd0);

      // Short start pulse is rejected
      loads0 = n_loads;
      @(posedge clk); #1 rx = 1'b0;
      idle_cycles(20);
      rx = 1'b1;
      idle_cycles(700);
      check("glitch_loads", n_loads - loads0, 32'd0);
      check("glitch_ferr", n_ferr, 32'd0);
      check("glitch_idle", {31'd0, dut.r_state == ST_IDLE}, 32'd1);

      // Stop bit 0 with line held low, then a clean frame
      loads0 = n_loads;
      drive_frame({1'b0, 8'h3C, 1'b0}, 10 * c_BIT_CYC);
      idle_cycles(200);
      check("ferr_pulses", n_ferr, 32'd1);
      check("ferr_no_valid", n_loads - loads0, 32'd0);
      rx = 1'b1;
      idle_cycles(100);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      idle_cycles(10);
      check("ferr_recovery_loads", n_loads - loads0, 32'd1);
      pulse_ready();
      idle_cycles(5);
      check("ferr_queue_empty", exp_q.size(), 32'd0);

      // Overrun: second byte dropped while first is unread
      exp_q.push_back(8'h11);
      send_byte(8'h11);
      send_byte(8'h22);
      idle_cycles(10);
      check("ovr_pulses", n_ovr, 32'd1);
      check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
      pulse_ready();
      idle_cycles(5);
      check("ovr_queue_empty", exp_q.size(), 32'd0);

      // Continuous ready, back-to-back frames
      loads0 = n_loads;
      rx_ready = 1'b1;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      send_byte(8'h55);
      send_byte(8'hAA);
      idle_cycles(10);
      rx_ready = 1'b0;
      check("b2b_loads", n_loads - loads0, 32'd2);
      check("b2b_no_overrun", n_ovr, 32'd1);
      check("b2b_queue_empty", exp_q.size(), 32'd0);

      // Reset during bit 3, then a fresh frame
      drive_frame({1'b1, 8'hC3, 1'b0}, 4 * c_BIT_CYC + 30);
      reset_n = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
      check("midrst_flags", {30'd0, framing_err, overrun}, 32'd0);
      idle_cycles(5);
      reset_n = 1'b1;
      idle_cycles(100);
      loads0 = n_loads;
      exp_q.push_back(8'h5A);
      send_byte(8'h5A);
      idle_cycles(10);
      check("midrst_loads", n_loads - loads0, 32'd1);
      check("midrst_data", {24'd0, rx_data}, 32'h5A);
      pulse_ready();
      idle_cycles(5);
      check("midrst_flags_total", n_ferr + n_ovr, 32'd2);
      check("midrst_queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
